xdatabus_mem_resp: RTL and testbench

- Memory-side responder for the native databus valid/ready interface driven by the versat read/write FUs.
- Serves N_PORTS independent master ports from one internal single-port byte-enable RAM, arbitrating round-robin.
- One access at a time.
- Stands in for external memory in simulation and on-chip buffer configurations, sitting between the versat databus outputs and storage.

---
 rtl/xdatabus_mem_resp_pkg.sv | 15 +
 rtl/xdatabus_mem_resp_if.sv | 23 ++
 rtl/xdatabus_mem_resp_ram.sv | 30 +++
 rtl/xdatabus_mem_resp.sv | 131 +++++++++++++
 tb/tb_xdatabus_mem_resp.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/xdatabus_mem_resp_pkg.sv
// Shared types and helpers for the databus memory responder.
package xdatabus_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Width of the byte-offset field inside a databus address.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/xdatabus_mem_resp_if.sv
// Flattened N-port native databus (valid/ready) bundle.
interface xdatabus_mem_resp_if #(
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32
);
  logic [N_PORTS-1:0]          databus_valid;
  logic [N_PORTS*ADDR_W-1:0]   databus_addr;
  logic [N_PORTS*DATA_W-1:0]   databus_wdata;
  logic [N_PORTS*DATA_W/8-1:0] databus_wstrb;
  logic [N_PORTS-1:0]          databus_ready;
  logic [N_PORTS*DATA_W-1:0]   databus_rdata;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb,
    input  databus_ready, databus_rdata
  );

  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb,
    output databus_ready, databus_rdata
  );
endinterface

// File: rtl/xdatabus_mem_resp_ram.sv
// Single-port synchronous RAM with byte enables and one-cycle read latency.
module databus_ram #(
  parameter int DATA_W     = 256,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);
  logic [DATA_W-1:0] mem_q [2**MEM_ADDR_W];
  logic [DATA_W-1:0] dout_q;

  // Read returns the old word on a write cycle; callers ignore dout after writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be[b]) mem_q[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/xdatabus_mem_resp.sv
// Memory-side responder: N databus master ports share one byte-enable RAM,
// served one access at a time in round-robin order (IDLE -> ACCESS -> RESP).
module xdatabus_mem_resp
  import xdatabus_mem_resp_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  xdatabus_mem_resp_if.slave   bus
);
  localparam int BYTE_OFF_W = byte_off_w(DATA_W);
  localparam int STRB_W     = DATA_W / 8;
  localparam int PTR_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          grant_q, grant_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      is_wr_q, is_wr_d;
  logic [N_PORTS*DATA_W-1:0] rdata_q, rdata_d;

  logic [N_PORTS-1:0]        ready_o;
  logic [N_PORTS*DATA_W-1:0] rdata_o;

  logic                      ram_en;
  logic                      ram_we;
  logic [STRB_W-1:0]         ram_be;
  logic [MEM_ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]         ram_din;
  logic [DATA_W-1:0]         ram_dout;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [2*N_PORTS-1:0] dbl;
    logic [N_PORTS-1:0]   rot;
    int                   sel;
    logic                 found;
    dbl   = {req, req};
    rot   = dbl[int'(ptr) +: N_PORTS];
    sel   = 0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && rot[i]) begin
        sel   = i;
        found = 1'b1;
      end
    end
    sel = sel + int'(ptr);
    if (sel >= N_PORTS) sel = sel - N_PORTS;
    return sel[PTR_W-1:0];
  endfunction

  // RAM is driven from the granted port; high address bits wrap, low bits are byte offset.
  assign ram_en   = (state_q == ACCESS);
  assign ram_be   = bus.databus_wstrb[int'(grant_q)*STRB_W +: STRB_W];
  assign ram_we   = |ram_be;
  assign ram_addr = bus.databus_addr[int'(grant_q)*ADDR_W + BYTE_OFF_W +: MEM_ADDR_W];
  assign ram_din  = bus.databus_wdata[int'(grant_q)*DATA_W +: DATA_W];

  databus_ram #(
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      is_wr_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      is_wr_q  <= is_wr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    is_wr_d  = is_wr_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (|bus.databus_valid) begin
          grant_d = rr_pick(bus.databus_valid, rr_ptr_q);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        is_wr_d = ram_we;
        state_d = RESP;
      end
      RESP: begin
        if (!is_wr_q) rdata_d[int'(grant_q)*DATA_W +: DATA_W] = ram_dout;
        rr_ptr_d = (int'(grant_q) == N_PORTS-1) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded straight from the RAM in the ready cycle, then held in rdata_q.
  always_comb begin
    ready_o = '0;
    rdata_o = rdata_q;
    if (state_q == RESP) begin
      ready_o[grant_q] = 1'b1;
      if (!is_wr_q) rdata_o[int'(grant_q)*DATA_W +: DATA_W] = ram_dout;
    end
  end

  assign bus.databus_ready = ready_o;
  assign bus.databus_rdata = rdata_o;
endmodule

// File: tb/tb_xdatabus_mem_resp.sv
// Directed scoreboard bench for xdatabus_mem_resp (2 ports, 256-bit words).
module tb_xdatabus_mem_resp;
  localparam int NP = 2;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    int            port;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   errors;
  int   checks;
  logic          hold_chk;
  logic [DW-1:0] hold_val;

  xdatabus_mem_resp_if #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

  xdatabus_mem_resp #(
    .N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.databus_ready != '0) begin
        check("ready_onehot", DW'($countones(bus.databus_ready)), DW'(1));
      end
      for (int p = 0; p < NP; p++) begin
        if (bus.databus_ready[p]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ready_port", DW'(p), DW'(99));
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("grant_port", DW'(p), DW'(e.port));
            if (e.is_read) check("rdata", bus.databus_rdata[p*DW +: DW], e.data);
          end
        end
      end
      if (hold_chk) begin
        check("hold_rdata1", bus.databus_rdata[DW +: DW], hold_val);
        check("hold_ready1", DW'(bus.databus_ready[1]), DW'(0));
      end
    end
  end

  task automatic issue(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws, input logic [DW-1:0] exp);
    exp_t e;
    bus.databus_addr[p*AW +: AW]  = a;
    bus.databus_wdata[p*DW +: DW] = wd;
    bus.databus_wstrb[p*SW +: SW] = ws;
    bus.databus_valid[p]          = 1'b1;
    e.port    = p;
    e.is_read = (ws == '0);
    e.data    = exp;
    sb_q.push_back(e);
  endtask

  // Counts falling edges until ready[p]; cycle-of-issue counts as 0.
  task automatic wait_ready(input int p);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.databus_ready[p]) break;
    end
    if (!bus.databus_ready[p]) check("ready_timeout", DW'(0), DW'(1));
    else check("latency", DW'(n - 1), DW'(2));
  endtask

  task automatic xfer(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] ws, input logic [DW-1:0] exp);
    issue(p, a, wd, ws, exp);
    wait_ready(p);
    @(posedge clk); #1;
    bus.databus_valid[p] = 1'b0;
  endtask

  localparam logic [SW-1:0] ALL = '1;
  localparam logic [SW-1:0] RD  = '0;

  initial begin
    errors = 0;
    checks = 0;
    hold_chk = 1'b0;
    hold_val = '0;
    rst = 1'b0;
    bus.databus_valid = '0;
    bus.databus_addr  = '0;
    bus.databus_wdata = '0;
    bus.databus_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", DW'(bus.databus_ready), DW'(0));
    check("reset_rdata0", bus.databus_rdata[0 +: DW], '0);
    check("reset_rdata1", bus.databus_rdata[DW +: DW], '0);
    rst = 1'b1;

    // Contention: both ports from reset; port0 re-requests right after its ready.
    @(posedge clk); #1;
    issue(0, 32'h100, {32{8'hC0}}, ALL, '0);
    issue(1, 32'h120, {32{8'hC1}}, ALL, '0);
    wait_ready(0);
    @(posedge clk); #1;
    issue(0, 32'h140, {32{8'hC2}}, ALL, '0);
    wait_ready(1);
    @(posedge clk); #1;
    bus.databus_valid[1] = 1'b0;
    wait_ready(0);
    @(posedge clk); #1;
    bus.databus_valid[0] = 1'b0;
    xfer(1, 32'h100, '0, RD, {32{8'hC0}});
    xfer(0, 32'h120, '0, RD, {32{8'hC1}});
    xfer(1, 32'h140, '0, RD, {32{8'hC2}});

    // Single write/read.
    xfer(0, 32'h40, {32{8'hA5}}, ALL, '0);
    xfer(0, 32'h40, '0, RD, {32{8'hA5}});

    // Byte strobes.
    xfer(0, 32'h80, {32{8'h11}}, ALL, '0);
    xfer(0, 32'h80, {32{8'hFF}}, SW'(32'h0000000F), '0);
    xfer(0, 32'h80, '0, RD, {{28{8'h11}}, {4{8'hFF}}});

    // Address wrap: 0x8000 is word 1024 -> word 0.
    xfer(1, 32'h0, DW'(32'hDEAD), ALL, '0);
    xfer(0, 32'h8000, '0, RD, DW'(32'hDEAD));

    // Hold/isolation: port1 rdata must not move while port0 writes.
    xfer(1, 32'hA0, DW'(8'h55), ALL, '0);
    xfer(1, 32'hA0, '0, RD, DW'(8'h55));
    hold_val = DW'(8'h55);
    hold_chk = 1'b1;
    xfer(0, 32'h200, {32{8'h01}}, ALL, '0);
    xfer(0, 32'h220, {32{8'h02}}, ALL, '0);
    xfer(0, 32'h240, {32{8'h03}}, ALL, '0);
    hold_chk = 1'b0;

    // Reset during ACCESS: outputs clear at once, no ready.
    issue(0, 32'h40, '0, RD, {32{8'hA5}});
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", DW'(bus.databus_ready), DW'(0));
    check("midrst_rdata0", bus.databus_rdata[0 +: DW], '0);
    check("midrst_rdata1", bus.databus_rdata[DW +: DW], '0);
    sb_q.delete();
    bus.databus_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    xfer(1, 32'hA0, '0, RD, DW'(8'h55));

    repeat (3) @(posedge clk);
    check("sb_empty", DW'(sb_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
